parking_gate_arbiter: RTL

- Arbitrates one shared barrier gate in a single-lane car park between an entry requester (ticket button) and an exit requester (exit reader).
- Tracks lot occupancy from the `entering`/`exiting` pulses produced by the lane sensor FSM.
- Blocks entry when the lot is full.
- Sits between the sensor FSM and the gate motor driver.

---
 rtl/parking_gate_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between the entry and exit
// requesters of a single-lane car park and tracks lot occupancy from the
// lane sensor pulses.
// Optional build macro: OCC_PRELOAD_EN adds load_en/load_val for a manual recount.
// rst_n is asynchronous and ACTIVE-HIGH despite its name.
module parking_gate_arbiter #(
  parameter int CAPACITY  = 8,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 16,
  parameter int CLOSE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             entering,
  input  logic             exiting,
`ifdef OCC_PRELOAD_EN
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
`endif
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             err
);

  // One timer serves both the open-wait and the closing hold-off.
  localparam int TMR_MAX = (TIMEOUT > CLOSE_CYC) ? TIMEOUT : CLOSE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    CLOSING  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               last_dir, last_dir_nxt;
  logic               in_ok;
  logic               open_hit;
  logic               close_hit;
  logic [CNT_W-1:0]   occ_nxt;
  logic               err_set;

  assign in_ok     = req_in && !full;
  assign open_hit  = (timer == TMR_W'(TIMEOUT - 1));
  assign close_hit = (timer == TMR_W'(CLOSE_CYC - 1));

  // Moore gate controls decoded straight from the state register.
  assign gate_open = (state == OPEN_IN) || (state == OPEN_OUT);
  assign grant_in  = (state == OPEN_IN);
  assign grant_out = (state == OPEN_OUT);

  // Flag the last open cycle when the served car has not passed.
  assign timeout = open_hit &&
                   (((state == OPEN_IN) && !entering) ||
                    ((state == OPEN_OUT) && !exiting));

  // Next-state, timer and round-robin direction.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    last_dir_nxt = last_dir;
    case (state)
      IDLE: begin
        if (in_ok && (!req_out || (last_dir == DIR_OUT))) begin
          state_nxt    = OPEN_IN;
          last_dir_nxt = DIR_IN;
          timer_nxt    = '0;
        end else if (req_out) begin
          state_nxt    = OPEN_OUT;
          last_dir_nxt = DIR_OUT;
          timer_nxt    = '0;
        end
      end
      OPEN_IN: begin
        if (entering || open_hit) begin
          state_nxt = CLOSING;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      OPEN_OUT: begin
        if (exiting || open_hit) begin
          state_nxt = CLOSING;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      CLOSING: begin
        if (close_hit) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Occupancy update: sensors are truth, saturate at both ends and flag it.
  always_comb begin
    occ_nxt = occupancy;
    err_set = 1'b0;
    if (entering && !exiting) begin
      if (full) err_set = 1'b1;
      else      occ_nxt = occupancy + CNT_W'(1);
    end else if (exiting && !entering) begin
      if (empty) err_set = 1'b1;
      else       occ_nxt = occupancy - CNT_W'(1);
    end
`ifdef OCC_PRELOAD_EN
    if (load_en) begin
      if (load_val > CNT_W'(CAPACITY)) begin
        occ_nxt = CNT_W'(CAPACITY);
        err_set = 1'b1;
      end else begin
        occ_nxt = load_val;
        err_set = 1'b0;
      end
    end
`endif
  end

  // State, timer and occupancy registers; full/empty track the new count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      last_dir  <= DIR_OUT;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      last_dir  <= last_dir_nxt;
      occupancy <= occ_nxt;
      full      <= (occ_nxt == CNT_W'(CAPACITY));
      empty     <= (occ_nxt == '0);
      err       <= err | err_set;
    end
  end

endmodule
